demux_router: RTL and testbench
===============================

Name: demux_router

Overview:
- Inverse of the 4-to-1 tag-priority mux: takes one 12-bit word stream and routes each word to one of four output lanes.
- Routing uses the destination tag in bits [11:10].
- Each lane has its own small FIFO, so downstream consumers can drain lanes independently with a pop/valid handshake.
- Sits between the upstream link and the four per-lane consumers.

Parameters:
- DATA_WIDTH, 12, word width; the tag is always the two MSBs.
- FIFO_DEPTH, 4, entries per lane FIFO; must be a power of two.
- PTR_WIDTH, 2, log2(FIFO_DEPTH).
- ALMOST_FULL_LVL, 3, occupancy at which almost_full[i] asserts.

Ports:
- clk  input  1  rising-edge clock.
- reset_L  input  1  asynchronous, active-low reset.
- data_in  input  12  incoming word; [11:10] is the destination lane.
- valid_in  input  1  data_in is presented this cycle.
- ready_in  output  1  the lane addressed by data_in[11:10] is not full; combinational.
- pop  input  4  pop[i] requests one word from lane i.
- data_out0..data_out3  output  12 each  registered lane outputs.
- valid_out  output  4  valid_out[i] high for the one cycle data_outi carries a popped word.
- fifo_empty  output  4  lane i occupancy == 0.
- fifo_full  output  4  lane i occupancy == FIFO_DEPTH.
- almost_full  output  4  lane i occupancy >= ALMOST_FULL_LVL.
- overflow_err  output  1  sticky error flag.

Behaviour:
- Reset (reset_L low, asynchronous):
  - All read/write pointers and occupancy counters go to 0.
  - data_out0..3 = 0, valid_out = 0, overflow_err = 0.
  - fifo_empty = 4'hF, fifo_full = 0, almost_full = 0.
  - FIFO storage contents need not be cleared.
  - Reset mid-traffic discards all buffered words; the first cycle after release behaves as empty.
- Lane select: tag = data_in[11:10]; lane = tag.
- Idle code: data_in == 0 is never stored, even with valid_in high. No error and no state change.
- Push: push[tag] = valid_in & (data_in != 0) & ~fifo_full[tag].
  - The word is written at the lane's wr_ptr on the clock edge.
  - wr_ptr increments modulo FIFO_DEPTH; occupancy +1.
  - The full tag is stored unchanged.
- ready_in = ~fifo_full[data_in[11:10]]. It has no dependence on pop; there is no pass-through on full.
- Overflow: valid_in & (data_in != 0) & fifo_full[tag] drops the word and sets overflow_err. overflow_err stays set until reset.
- Pop: pop[i] & ~fifo_empty[i] loads data_outi with the word at rd_ptr[i] on the next edge.
  - valid_out[i] = 1 for that cycle only.
  - rd_ptr[i] increments modulo FIFO_DEPTH; occupancy -1.
  - Latency: pop sampled at edge N, data visible after edge N (one cycle).
- Pop on empty lane: ignored. valid_out[i] = 0, data_outi holds its last value, occupancy stays 0.
- Simultaneous push and pop, same lane:
  - Lane not empty: both happen and occupancy is unchanged.
  - Lane empty: the push happens and the pop is ignored; there is no same-cycle bypass.
  - Lane full: the push is rejected (overflow) and the pop proceeds.
- Lanes are fully independent: pushes to one lane and pops from any or all four lanes may occur in the same cycle.
- Status flags fifo_empty, fifo_full and almost_full derive from the registered occupancy counters, so they update the cycle after the push or pop.
- Pointer wrap: after FIFO_DEPTH pushes and pops, pointers return to 0 with no loss or reordering. Per-lane order is strict FIFO.
- data_out registers hold their value when there is no valid pop. Consumers qualify data with valid_out only.

Test Plan:
- Reset then push 12'h005, 12'h401, 12'h802, 12'hC03 on consecutive cycles, then pop = 4'hF -> next cycle data_out0..3 = 005/401/802/C03, valid_out = 4'hF, fifo_empty = 4'hF afterwards.
- Push 5 words tagged lane 2 (12'h811..12'h815) with no pops:
  - After the 4th push, fifo_full[2] = 1 and ready_in = 0 for a lane-2 tag.
  - almost_full[2] = 1 after the 3rd push.
  - The 5th word is dropped and overflow_err = 1.
  - Popping 4 times yields 811..814 in order.
- Present data_in = 12'h000 with valid_in = 1 for 3 cycles -> no occupancy change and overflow_err stays 0. Also pop empty lane 1 -> valid_out[1] = 0, data_out1 unchanged.
- Fill lane 3 to 2 entries, then push 12'hC0A and pop[3] in the same cycle -> occupancy stays 2, popped word is the oldest. Push and pop on an empty lane 0 -> occupancy 1, valid_out[0] = 0.
- Stream 10 words into lane 1 while popping every cycle after the first -> outputs appear in input order with one-cycle latency, and pointers wrap twice without loss.
- Load all lanes to 2 entries, assert reset_L low asynchronously mid-cycle -> data_out all 0, valid_out = 0, fifo_empty = 4'hF, overflow_err = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/demux_router.sv
// Tag-steered 1-to-4 demultiplexer: each non-zero word is queued in the lane named by its
// two MSBs, and each lane is drained independently through a pop/valid handshake.
module demux_router #(
    parameter int DATA_WIDTH      = 12,
    parameter int FIFO_DEPTH      = 4,
    parameter int PTR_WIDTH       = 2,
    parameter int ALMOST_FULL_LVL = 3
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    input  logic [3:0]            pop,
    output logic [DATA_WIDTH-1:0] data_out0,
    output logic [DATA_WIDTH-1:0] data_out1,
    output logic [DATA_WIDTH-1:0] data_out2,
    output logic [DATA_WIDTH-1:0] data_out3,
    output logic [3:0]            valid_out,
    output logic [3:0]            fifo_empty,
    output logic [3:0]            fifo_full,
    output logic [3:0]            almost_full,
    output logic                  overflow_err
);

    localparam int LANES = 4;
    localparam int CNT_W = PTR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q  [LANES][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d  [LANES][FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_q [LANES];
    logic [PTR_WIDTH-1:0]  wr_ptr_d [LANES];
    logic [PTR_WIDTH-1:0]  rd_ptr_q [LANES];
    logic [PTR_WIDTH-1:0]  rd_ptr_d [LANES];
    logic [CNT_W-1:0]      cnt_q    [LANES];
    logic [CNT_W-1:0]      cnt_d    [LANES];
    logic [DATA_WIDTH-1:0] dout_q   [LANES];
    logic [DATA_WIDTH-1:0] dout_d   [LANES];
    logic [LANES-1:0]      valid_q, valid_d;
    logic                  ovf_q, ovf_d;

    logic [1:0]            tag;
    logic                  word_ok;
    logic [LANES-1:0]      push, pop_ok, empty, full, afull;

    // The all-zero word is the link's idle code and is never queued.
    assign tag      = data_in[DATA_WIDTH-1 -: 2];
    assign word_ok  = valid_in && (data_in != '0);
    assign ready_in = ~full[tag];

    always_comb begin
        empty = '0;
        full  = '0;
        afull = '0;
        for (int i = 0; i < LANES; i++) begin
            empty[i] = (cnt_q[i] == '0);
            full[i]  = (cnt_q[i] == CNT_W'(FIFO_DEPTH));
            afull[i] = (cnt_q[i] >= CNT_W'(ALMOST_FULL_LVL));
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        push     = '0;
        pop_ok   = '0;
        valid_d  = '0;
        ovf_d    = ovf_q | (word_ok & full[tag]);
        for (int i = 0; i < LANES; i++) begin
            // Full/empty come from the registered count, so a full lane rejects a push
            // even while it is being popped, and an empty lane never bypasses to the output.
            push[i]   = word_ok && (tag == 2'(i)) && !full[i];
            pop_ok[i] = pop[i] && !empty[i];
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = data_in;
                wr_ptr_d[i]           = wr_ptr_q[i] + PTR_WIDTH'(1);
            end
            if (pop_ok[i]) begin
                dout_d[i]   = mem_q[i][rd_ptr_q[i]];
                rd_ptr_d[i] = rd_ptr_q[i] + PTR_WIDTH'(1);
                valid_d[i]  = 1'b1;
            end
            cnt_d[i] = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop_ok[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int i = 0; i < LANES; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
                dout_q[i]   <= '0;
            end
            valid_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign data_out0    = dout_q[0];
    assign data_out1    = dout_q[1];
    assign data_out2    = dout_q[2];
    assign data_out3    = dout_q[3];
    assign valid_out    = valid_q;
    assign fifo_empty   = empty;
    assign fifo_full    = full;
    assign almost_full  = afull;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_demux_router.sv
// Bench for demux_router: fixed vector table, directed corner sequences and a random run,
// all checked against per-lane queue model.
module tb_demux_router;

    logic        clk = 1'b0;
    logic        reset_L;
    logic [11:0] din;
    logic        vin;
    logic        ready_in;
    logic [3:0]  pop;
    logic [11:0] data_out0, data_out1, data_out2, data_out3;
    logic [3:0]  valid_out, fifo_empty, fifo_full, almost_full;
    logic        overflow_err;
    logic [11:0] dout_w [4];

    int n_cmp = 0;
    int n_err = 0;

    logic [11:0] mq [4][$];
    logic [11:0] m_dout [4];
    logic [3:0]  m_valid;
    logic        m_ovf;

    typedef struct {
        logic        vin;
        logic [11:0] din;
        logic [3:0]  pop;
        logic [3:0]  e_valid, e_empty, e_full, e_af;
        logic        e_ovf, e_ready;
        int          dsel;
        logic [11:0] e_d;
    } vec_t;
    vec_t tbl [14];

    demux_router dut (
        .clk(clk), .reset_L(reset_L), .data_in(din), .valid_in(vin), .ready_in(ready_in),
        .pop(pop), .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2),
        .data_out3(data_out3), .valid_out(valid_out), .fifo_empty(fifo_empty),
        .fifo_full(fifo_full), .almost_full(almost_full), .overflow_err(overflow_err)
    );

    assign dout_w[0] = data_out0;
    assign dout_w[1] = data_out1;
    assign dout_w[2] = data_out2;
    assign dout_w[3] = data_out3;

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            mq[i].delete();
            m_dout[i] = '0;
        end
        m_valid = '0;
        m_ovf   = 1'b0;
    endfunction

    function automatic void check_all(string tagname);
        logic [3:0] e_empty, e_full, e_af;
        for (int i = 0; i < 4; i++) begin
            e_empty[i] = (mq[i].size() == 0);
            e_full[i]  = (mq[i].size() == 4);
            e_af[i]    = (mq[i].size() >= 3);
            chk($sformatf("%s data_out%0d", tagname, i), 32'(dout_w[i]), 32'(m_dout[i]));
        end
        chk({tagname, " valid_out"}, 32'(valid_out), 32'(m_valid));
        chk({tagname, " fifo_empty"}, 32'(fifo_empty), 32'(e_empty));
        chk({tagname, " fifo_full"}, 32'(fifo_full), 32'(e_full));
        chk({tagname, " almost_full"}, 32'(almost_full), 32'(e_af));
        chk({tagname, " overflow_err"}, 32'(overflow_err), 32'(m_ovf));
        chk({tagname, " ready_in"}, 32'(ready_in), 32'(mq[din[11:10]].size() < 4));
    endfunction

    // Advance the model by one clock using the current inputs, then step the DUT.
    task automatic tick();
        logic [1:0] t;
        bit         push_ok;
        t       = din[11:10];
        push_ok = vin && (din != 0) && (mq[t].size() < 4);
        if (vin && (din != 0) && (mq[t].size() >= 4)) m_ovf = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            if (pop[i] && mq[i].size() > 0) begin
                m_dout[i]  = mq[i].pop_front();
                m_valid[i] = 1'b1;
            end
        end
        if (push_ok) mq[t].push_back(din);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic v, logic [11:0] d, logic [3:0] p);
        vin = v;
        din = d;
        pop = p;
    endtask

    // Reset asserted away from any clock edge; outputs must clear before the next edge.
    task automatic async_reset(string nm);
        #2;
        reset_L = 1'b0;
        model_reset();
        #1;
        check_all(nm);
        #2;
        reset_L = 1'b1;
        drive(0, 12'h000, 4'h0);
        tick();
    endtask

    initial begin
        reset_L = 1'b0;
        drive(0, 12'h000, 4'h0);
        model_reset();
        #1;
        check_all("reset");
        chk("reset fifo_empty const", 32'(fifo_empty), 32'hF);
        #12;
        reset_L = 1'b1;
        @(posedge clk);
        #1;

        tbl[0]  = '{1'b1, 12'h005, 4'h0, 4'h0, 4'hE, 4'h0, 4'h0, 1'b0, 1'b1, 0, 12'h000};
        tbl[1]  = '{1'b1, 12'h401, 4'h0, 4'h0, 4'hC, 4'h0, 4'h0, 1'b0, 1'b1, 0, 12'h000};
        tbl[2]  = '{1'b1, 12'h802, 4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 1'b0, 1'b1, 0, 12'h000};
        tbl[3]  = '{1'b1, 12'hC03, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 0, 12'h000};
        tbl[4]  = '{1'b0, 12'h000, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b1, 0, 12'h005};
        tbl[5]  = '{1'b1, 12'h811, 4'h0, 4'h0, 4'hB, 4'h0, 4'h0, 1'b0, 1'b1, 2, 12'h802};
        tbl[6]  = '{1'b1, 12'h812, 4'h0, 4'h0, 4'hB, 4'h0, 4'h0, 1'b0, 1'b1, 2, 12'h802};
        tbl[7]  = '{1'b1, 12'h813, 4'h0, 4'h0, 4'hB, 4'h0, 4'h4, 1'b0, 1'b1, 2, 12'h802};
        tbl[8]  = '{1'b1, 12'h814, 4'h0, 4'h0, 4'hB, 4'h4, 4'h4, 1'b0, 1'b0, 2, 12'h802};
        tbl[9]  = '{1'b1, 12'h815, 4'h0, 4'h0, 4'hB, 4'h4, 4'h4, 1'b1, 1'b0, 2, 12'h802};
        tbl[10] = '{1'b0, 12'h000, 4'h4, 4'h4, 4'hB, 4'h0, 4'h4, 1'b1, 1'b1, 2, 12'h811};
        tbl[11] = '{1'b0, 12'h000, 4'h4, 4'h4, 4'hB, 4'h0, 4'h0, 1'b1, 1'b1, 2, 12'h812};
        tbl[12] = '{1'b0, 12'h000, 4'h4, 4'h4, 4'hB, 4'h0, 4'h0, 1'b1, 1'b1, 2, 12'h813};
        tbl[13] = '{1'b0, 12'h000, 4'h4, 4'h4, 4'hF, 4'h0, 4'h0, 1'b1, 1'b1, 2, 12'h814};

        for (int r = 0; r < 14; r++) begin
            drive(tbl[r].vin, tbl[r].din, tbl[r].pop);
            tick();
            chk($sformatf("vec%0d valid_out", r), 32'(valid_out), 32'(tbl[r].e_valid));
            chk($sformatf("vec%0d fifo_empty", r), 32'(fifo_empty), 32'(tbl[r].e_empty));
            chk($sformatf("vec%0d fifo_full", r), 32'(fifo_full), 32'(tbl[r].e_full));
            chk($sformatf("vec%0d almost_full", r), 32'(almost_full), 32'(tbl[r].e_af));
            chk($sformatf("vec%0d overflow_err", r), 32'(overflow_err), 32'(tbl[r].e_ovf));
            chk($sformatf("vec%0d ready_in", r), 32'(ready_in), 32'(tbl[r].e_ready));
            chk($sformatf("vec%0d data_out%0d", r, tbl[r].dsel), 32'(dout_w[tbl[r].dsel]),
                32'(tbl[r].e_d));
            check_all($sformatf("vec%0d model", r));
            if (r == 4) begin
                chk("all_lanes data_out1", 32'(data_out1), 32'h401);
                chk("all_lanes data_out2", 32'(data_out2), 32'h802);
                chk("all_lanes data_out3", 32'(data_out3), 32'hC03);
            end
        end

        async_reset("reset_after_ovf");

        // Idle code never stored; then a pop on an empty lane leaves data_out1 alone.
        for (int k = 0; k < 3; k++) begin
            drive(1, 12'h000, 4'h0);
            tick();
            check_all("idle");
        end
        chk("idle fifo_empty", 32'(fifo_empty), 32'hF);
        chk("idle overflow_err", 32'(overflow_err), 32'h0);
        drive(1, 12'h4AB, 4'h0);
        tick();
        drive(0, 12'h000, 4'h2);
        tick();
        chk("lane1 pop data", 32'(data_out1), 32'h4AB);
        drive(0, 12'h000, 4'h2);
        tick();
        chk("empty pop valid_out1", 32'(valid_out[1]), 32'h0);
        chk("empty pop data_out1 held", 32'(data_out1), 32'h4AB);
        check_all("empty_pop");

        // Simultaneous push and pop on lane 3 (non-empty) and lane 0 (empty).
        drive(1, 12'hC01, 4'h0);
        tick();
        drive(1, 12'hC02, 4'h0);
        tick();
        drive(1, 12'hC0A, 4'h8);
        tick();
        chk("lane3 pushpop data", 32'(data_out3), 32'hC01);
        chk("lane3 pushpop valid", 32'(valid_out), 32'h8);
        check_all("lane3_pushpop");
        drive(0, 12'h000, 4'h8);
        tick();
        chk("lane3 drain1", 32'(data_out3), 32'hC02);
        drive(0, 12'h000, 4'h8);
        tick();
        chk("lane3 drain2", 32'(data_out3), 32'hC0A);
        chk("lane3 empty after 2", 32'(fifo_empty[3]), 32'h1);
        drive(1, 12'h0B7, 4'h1);
        tick();
        chk("lane0 pushpop valid", 32'(valid_out[0]), 32'h0);
        chk("lane0 pushpop not empty", 32'(fifo_empty[0]), 32'h0);
        check_all("lane0_pushpop");
        drive(0, 12'h000, 4'h1);
        tick();
        chk("lane0 pushpop drain", 32'(data_out0), 32'h0B7);

        // Streaming into lane 1 with a pop every cycle after the first; pointers wrap.
        for (int k = 0; k < 11; k++) begin
            if (k < 10) drive(1, 12'h410 + 12'(k), (k > 0) ? 4'h2 : 4'h0);
            else        drive(0, 12'h000, 4'h2);
            tick();
            if (k > 0) begin
                chk($sformatf("stream%0d data", k), 32'(data_out1), 32'h410 + 32'(k - 1));
                chk($sformatf("stream%0d valid", k), 32'(valid_out[1]), 32'h1);
            end
            check_all("stream");
        end
        chk("stream empty", 32'(fifo_empty), 32'hF);

        // Randomized traffic against the queue model.
        for (int k = 0; k < 400; k++) begin
            logic [11:0] w;
            w = 12'($urandom);
            if ($urandom_range(0, 7) == 0) w = 12'h000;
            drive(1'($urandom_range(0, 3) != 0), w, 4'($urandom) & 4'($urandom));
            tick();
            check_all($sformatf("rand%0d", k));
        end
        drive(0, 12'h000, 4'h0);
        tick();

        async_reset("reset_pre_load");
        for (int l = 0; l < 4; l++) begin
            for (int k = 0; k < 3; k++) begin
                drive(1, {2'(l), 10'h020 + 10'(k)}, 4'h0);
                tick();
            end
        end
        drive(0, 12'h000, 4'hF);
        tick();
        check_all("preload_pop");
        drive(0, 12'h000, 4'h0);
        tick();
        async_reset("reset_midtraffic");
        chk("mid reset data_out0", 32'(data_out0), 32'h0);
        chk("mid reset fifo_empty", 32'(fifo_empty), 32'hF);
        drive(1, 12'h807, 4'h4);
        tick();
        chk("post reset empty pop valid", 32'(valid_out), 32'h0);
        check_all("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
